// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm feeder blocks: default counter width and the
// saturating slew helper that moves a duty word toward its target.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  // Helper operates at a fixed wide width so any feeder width up to 31 bits can
  // zero-extend into it and truncate the result back.
  localparam int CALC_W = 32;

  typedef logic [CALC_W-1:0] calc_t;

  // Next threshold one period later: jump when step is 0 or the gap is small,
  // otherwise move by exactly step toward tgt (never passes tgt, so no wrap).
  function automatic calc_t step_toward(input calc_t cur, input calc_t tgt, input calc_t step);
    logic [CALC_W:0] diff;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
    end
    if ((step == '0) || (diff <= {1'b0, step})) begin
      return tgt;
    end else if (tgt > cur) begin
      return cur + step;
    end else begin
      return cur - step;
    end
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter shared with the pwm stage; flags the first cycle
// of every period except the one straight out of reset.
`timescale 1ns/1ps
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] cnt,
  output logic             period_start
);

  logic [WIDTH-1:0] cnt_reg;
  logic             period_start_reg;
  logic             wrap;

  assign wrap = (cnt_reg == {WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_reg + 1'b1;
      period_start_reg <= wrap;
    end
  end

  assign cnt          = cnt_reg;
  assign period_start = period_start_reg;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-word feeder for pwm: takes targets over valid/ready and slews the
// threshold toward them by at most STEP counts, updating only at period wrap.
`timescale 1ns/1ps
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int STEP  = 1,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_target,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] threshold,
  output logic             period_start,
  output logic             busy
);

  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  localparam calc_t            STEP_W = CALC_W'(STEP);

  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic             xfer;
  logic [WIDTH-1:0] tgt_eff;

  logic [WIDTH-1:0] threshold_reg, threshold_next;
  logic [WIDTH-1:0] target_reg, target_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             pend_vld_reg, pend_vld_next;
  logic             busy_reg, busy_next;

  pwm_period_counter #(
    .WIDTH(WIDTH)
  ) u_period_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .cnt         (cnt),
    .period_start(period_start)
  );

  assign wrap    = &cnt;
  assign s_ready = ~pend_vld_reg;
  assign xfer    = s_valid && s_ready;

  always_comb begin
    threshold_next = threshold_reg;
    target_next    = target_reg;
    pend_next      = pend_reg;
    pend_vld_next  = pend_vld_reg;
    tgt_eff        = pend_vld_reg ? pend_reg : target_reg;

    if (wrap) begin
      target_next    = tgt_eff;
      pend_vld_next  = 1'b0;
      threshold_next = WIDTH'(step_toward(CALC_W'(threshold_reg), CALC_W'(tgt_eff), STEP_W));
    end

    // Applied after the wrap update so a transfer on the wrap edge waits a period.
    if (xfer) begin
      pend_next     = s_target;
      pend_vld_next = 1'b1;
    end

    busy_next = pend_vld_next || (threshold_next != target_next);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      threshold_reg <= INIT_W;
      target_reg    <= INIT_W;
      pend_reg      <= '0;
      pend_vld_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      threshold_reg <= threshold_next;
      target_reg    <= target_next;
      pend_reg      <= pend_next;
      pend_vld_reg  <= pend_vld_next;
      busy_reg      <= busy_next;
    end
  end

  assign threshold = threshold_reg;
  assign busy      = busy_reg;

endmodule
